float_div_iter: RTL and testbench
=================================

FLOAT_DIV_ITER -- requirements
Module: float_div_iter

Interface
REQ-001 Parameters: none; all widths are fixed by float_pkg (IEEE-754 binary32).
REQ-002 clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 floatA  input  32  dividend (binary32).
REQ-006 floatB  input  32  divisor (binary32).
REQ-007 floatQuot  output  32  registered quotient; held from done until the next done.
REQ-008 busy  output  1  high from the cycle after start is accepted through the done cycle.
REQ-009 done  output  1  one-cycle pulse when floatQuot is valid.
REQ-010 divByZero  output  1  finite nonzero / zero; valid with done, held with floatQuot.
REQ-011 invalid  output  1  NaN operand, 0/0 or inf/inf; valid with done, held with floatQuot.

Function
REQ-012 FSM states: IDLE, UNPACK, DIVIDE, ROUND, DONE.
- IDLE->UNPACK on start=1; floatA/floatB are captured on that edge.
- UNPACK->DONE for special operands.
- UNPACK->DIVIDE otherwise.
- DIVIDE->ROUND after 26 iterations.
- ROUND->DONE.
- DONE->IDLE unconditionally.
REQ-013 Latency, with the start edge as edge 0:
- done is high after edge 28 for normal operands.
- done is high after edge 2 for special operands.
REQ-014 start while busy=1 shall be ignored; captured operands shall not change.
REQ-015 start asserted in the DONE cycle shall be ignored; a new start is accepted in IDLE only.
REQ-016 Subnormal inputs shall be treated as zero of the same sign (flush-to-zero).
REQ-017 Sign of the result = signA XOR signB, for all non-NaN results.
REQ-018 Special cases, with divByZero/invalid set only where noted:
- any NaN operand -> 0x7FC00000, invalid=1
- 0/0 or inf/inf -> 0x7FC00000, invalid=1
- finite/0 -> signed inf, divByZero=1
- inf/finite -> signed inf
- 0/nonzero -> signed zero
- finite/inf -> signed zero
REQ-019 Exponent arithmetic: 10-bit signed value expA - expB + 127.
REQ-020 Mantissa pre-normalisation: if mantA < mantB (each including the hidden 1), shift the dividend left by 1 and decrement the exponent by 1.
REQ-021 DIVIDE runs a restoring division producing one quotient bit per cycle.
- 26 bits total: 24 significand bits, guard, round.
- sticky = OR of the final remainder bits.
REQ-022 Exponent range after rounding:
- exponent >= 255 -> signed inf (flags 0)
- exponent <= 0 -> signed zero (output flush-to-zero)
REQ-023 A rounding carry out of the mantissa shall increment the exponent; the overflow check in REQ-022 is applied after that increment.

Reset
REQ-024 rst_n=0 shall immediately force:
- state = IDLE
- floatQuot, done, busy, divByZero, invalid = 0
- all internal registers = 0
REQ-025 Reset asserted mid-operation shall abort the operation; no done pulse shall follow.
REQ-026 After rst_n deasserts, the first start in IDLE shall be accepted normally.

Configuration
REQ-027 Macro FLOAT_DIV_RNE_EN:
- Defined: ROUND applies round-to-nearest-even using guard/round/sticky.
- Undefined: ROUND truncates toward zero, guard/round/sticky are ignored, and their logic is not synthesised.
- Latency is identical in both builds.

Structure
REQ-028 Package float_pkg shall hold:
- FLOAT_W = 32, EXP_W = 8, MANT_W = 23, BIAS = 127
- QNAN = 32'h7FC00000, POS_INF = 32'h7F800000
- the FSM state enum typedef
REQ-029 Sub-module mant_div_step: combinational single restoring-division step.
- Inputs: partial remainder, divisor.
- Outputs: next remainder, quotient bit.
- Instantiated once and iterated by the DIVIDE state.

Verification
REQ-030 The bench shall cover the following scenarios:
- 0x41A00000 (20.0) / 0x40800000 (4.0) -> 0x40A00000 (5.0); done after edge 28; flags 0.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB with FLOAT_DIV_RNE_EN defined, 0x3EAAAAAA without it.
- 0x3F800000 / 0x00000000 -> 0x7F800000, divByZero=1, done after edge 2.
- 0x80000000 / 0x00000000 -> 0x7FC00000, invalid=1.
- 0x7F7FFFFF / 0x00800000 -> 0x7F800000 (overflow); 0x00800000 / 0x7F7FFFFF -> 0x00000000 (underflow).
- start re-pulsed at edge 5 with different operands -> original result delivered.
- rst_n pulsed low at edge 10 -> all outputs 0, no done; a following start completes correctly.

Source files
------------

// File: rtl/float_pkg.sv
// Shared binary32 constants and FSM state encoding for the iterative divider.
// Build option FLOAT_DIV_RNE_EN selects round-to-nearest-even over truncation.
package float_pkg;

  localparam int FLOAT_W = 32;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int BIAS    = 127;
  localparam int QUO_W   = MANT_W + 3;

  localparam logic [FLOAT_W-1:0] QNAN    = 32'h7FC00000;
  localparam logic [FLOAT_W-1:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } state_t;

endpackage

// File: rtl/float_div_iter_step.sv
// One restoring-division step: subtract when possible, then shift left.
// Remainder is always below twice the divisor, so 25 bits suffice.
module mant_div_step
  import float_pkg::*;
(
  input  logic [MANT_W+1:0] rem_i,
  input  logic [MANT_W:0]   div_i,
  output logic [MANT_W+1:0] rem_o,
  output logic              q_o
);

  logic [MANT_W:0] diff;
  logic [MANT_W:0] keep;

  always_comb begin
    q_o   = (rem_i >= {1'b0, div_i});
    diff  = rem_i[MANT_W:0] - div_i;
    keep  = q_o ? diff : rem_i[MANT_W:0];
    rem_o = {keep, 1'b0};
  end

endmodule

// File: rtl/float_div_iter.sv
// Iterative binary32 divider, one quotient bit per cycle, flush-to-zero.
// FLOAT_DIV_RNE_EN enables round-to-nearest-even; otherwise truncates.
module float_div_iter
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] floatA,
  input  logic [31:0] floatB,
  output logic [31:0] floatQuot,
  output logic        busy,
  output logic        done,
  output logic        divByZero,
  output logic        invalid
);

  state_t state_q, state_d;

  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] res_q, res_d;
  logic [31:0] quot_q, quot_d;
  logic [MANT_W+1:0] rem_q, rem_d;
  logic [MANT_W:0] div_q, div_d;
  logic [QUO_W-1:0] quo_q, quo_d;
  logic [4:0] cnt_q, cnt_d;
  logic signed [9:0] exp_q, exp_d;
  logic sign_q, sign_d;
  logic fdbz_q, fdbz_d, finv_q, finv_d;
  logic odbz_q, odbz_d, oinv_q, oinv_d;
  logic done_q, done_d, busy_q, busy_d;

  logic [EXP_W-1:0] ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic [MANT_W:0] ma, mb;
  logic pre;
  logic [MANT_W+1:0] dvd;
  logic signed [9:0] e0;
  logic sgn;

  logic [MANT_W+1:0] step_rem, step_rem_nxt;
  logic [MANT_W:0] step_div;
  logic step_q;

  logic round_up;
  logic [MANT_W+1:0] mant_sum;
  logic carry;
  logic signed [9:0] exp_r;
  logic [MANT_W-1:0] frac_r;
  logic [31:0] rnd_res;

  // Subnormals fall into the zero class.
  always_comb begin
    ea = a_q[30:23];
    eb = b_q[30:23];
    fa = a_q[22:0];
    fb = b_q[22:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf = (ea == '1) && (fa == '0);
    b_inf = (eb == '1) && (fb == '0);
    a_nan = (ea == '1) && (fa != '0);
    b_nan = (eb == '1) && (fb != '0);
    sgn = a_q[31] ^ b_q[31];
    ma = {1'b1, fa};
    mb = {1'b1, fb};
    pre = (ma < mb);
    dvd = pre ? {ma, 1'b0} : {1'b0, ma};
    e0 = $signed({2'b00, ea})
       - $signed({2'b00, eb})
       + 10'(BIAS)
       - (pre ? 10'sd1 : 10'sd0);
  end

  // The first step runs on the UNPACK edge.
  always_comb begin
    step_rem = (state_q == S_UNPACK) ? dvd : rem_q;
    step_div = (state_q == S_UNPACK) ? mb : div_q;
  end

  mant_div_step u_step (
    .rem_i (step_rem),
    .div_i (step_div),
    .rem_o (step_rem_nxt),
    .q_o   (step_q)
  );

  always_comb begin
`ifdef FLOAT_DIV_RNE_EN
    round_up = quo_q[1]
             & (quo_q[0] | (|rem_q) | quo_q[2]);
`else
    round_up = 1'b0;
`endif
    mant_sum = {1'b0, quo_q[QUO_W-1:2]}
             + {{(MANT_W+1){1'b0}}, round_up};
    carry = mant_sum[MANT_W+1];
    exp_r = carry ? exp_q + 10'sd1 : exp_q;
    frac_r = carry ? mant_sum[MANT_W:1]
                   : mant_sum[MANT_W-1:0];
    if (exp_r >= 10'sd255) begin
      rnd_res = {sign_q, POS_INF[30:0]};
    end else if (exp_r <= 10'sd0) begin
      rnd_res = {sign_q, 31'd0};
    end else begin
      rnd_res = {sign_q, exp_r[7:0], frac_r};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    quot_d = quot_q;
    rem_d = rem_q;
    div_d = div_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    exp_d = exp_q;
    sign_d = sign_q;
    fdbz_d = fdbz_q;
    finv_d = finv_q;
    odbz_d = odbz_q;
    oinv_d = oinv_q;
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          a_d = floatA;
          b_d = floatB;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        fdbz_d = 1'b0;
        finv_d = 1'b0;
        state_d = S_DONE;
        if (a_nan || b_nan
            || (a_zero && b_zero)
            || (a_inf && b_inf)) begin
          res_d = QNAN;
          finv_d = 1'b1;
        end else if (a_inf) begin
          res_d = {sgn, POS_INF[30:0]};
        end else if (b_zero) begin
          res_d = {sgn, POS_INF[30:0]};
          fdbz_d = 1'b1;
        end else if (a_zero || b_inf) begin
          res_d = {sgn, 31'd0};
        end else begin
          rem_d = step_rem_nxt;
          div_d = mb;
          quo_d = {{(QUO_W-1){1'b0}}, step_q};
          exp_d = e0;
          sign_d = sgn;
          cnt_d = 5'd1;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        rem_d = step_rem_nxt;
        quo_d = {quo_q[QUO_W-2:0], step_q};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QUO_W - 1)) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        res_d = rnd_res;
        fdbz_d = 1'b0;
        finv_d = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        quot_d = res_q;
        odbz_d = fdbz_q;
        oinv_d = finv_q;
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE)
          || (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      quot_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      exp_q <= '0;
      sign_q <= 1'b0;
      fdbz_q <= 1'b0;
      finv_q <= 1'b0;
      odbz_q <= 1'b0;
      oinv_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      div_q <= div_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      exp_q <= exp_d;
      sign_q <= sign_d;
      fdbz_q <= fdbz_d;
      finv_q <= finv_d;
      odbz_q <= odbz_d;
      oinv_q <= oinv_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign floatQuot = quot_q;
  assign busy = busy_q;
  assign done = done_q;
  assign divByZero = odbz_q;
  assign invalid = oinv_q;

endmodule

// File: tb/tb_float_div_iter.sv
// Directed bench for float_div_iter: vector table plus
// start-while-busy, start-in-done-cycle and mid-op reset sequences.
module tb_float_div_iter;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [31:0] floatA, floatB;
  logic [31:0] floatQuot;
  logic busy, done, divByZero, invalid;

  int n_checks = 0;
  int n_fail = 0;

  float_div_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .floatA    (floatA),
    .floatB    (floatB),
    .floatQuot (floatQuot),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dz;
    logic        iv;
    int          lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

`ifdef FLOAT_DIV_RNE_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input string nm,
                        output logic [31:0] q,
                        output logic dz,
                        output logic iv,
                        output int lat);
    @(negedge clk);
    floatA = a;
    floatB = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_busy_start"}, busy, 1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    q = floatQuot;
    dz = divByZero;
    iv = invalid;
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done in 40 cycles", nm);
    end else begin
      chk({nm, "_busy_done"}, busy, 1);
      @(posedge clk);
      #1;
      chk({nm, "_done_pulse"}, done, 0);
      chk({nm, "_busy_end"}, busy, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    logic dz, iv;
    int lat;
    int seen;

    vecs[0]  = '{32'h41A00000, 32'h40800000, 32'h40A00000, 0, 0, 28};
    vecs[1]  = '{32'h3F800000, 32'h40400000, THIRD,        0, 0, 28};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, 2};
    vecs[3]  = '{32'h80000000, 32'h00000000, 32'h7FC00000, 0, 1, 2};
    vecs[4]  = '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 0, 0, 28};
    vecs[5]  = '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 0, 0, 28};
    vecs[6]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 1, 2};
    vecs[7]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 0, 1, 2};
    vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 2};
    vecs[9]  = '{32'h00000000, 32'hC0000000, 32'h80000000, 0, 0, 2};
    vecs[10] = '{32'hC0000000, 32'h7F800000, 32'h80000000, 0, 0, 2};
    vecs[11] = '{32'h00400000, 32'h3F800000, 32'h00000000, 0, 0, 2};
    vecs[12] = '{32'h3F800000, 32'h80400000, 32'hFF800000, 1, 0, 2};
    vecs[13] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 0, 0, 28};
    vecs[14] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 28};
    vecs[15] = '{32'h3F800000, 32'h7FC00001, 32'h7FC00000, 0, 1, 2};

    rst_n = 1'b0;
    start = 1'b0;
    floatA = '0;
    floatB = '0;
    #12;
    chk("rst_quot", floatQuot, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dbz", divByZero, 0);
    chk("rst_inv", invalid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      run_op(vecs[i].a, vecs[i].b, nm, q, dz, iv, lat);
      chk({nm, "_quot"}, q, vecs[i].q);
      chk({nm, "_dbz"}, dz, vecs[i].dz);
      chk({nm, "_inv"}, iv, vecs[i].iv);
      chk({nm, "_lat"}, lat, vecs[i].lat);
    end

    // start re-pulsed at edge 5 must not disturb the running op
    @(negedge clk);
    floatA = 32'h41A00000;
    floatB = 32'h40800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    floatA = 32'h3F800000;
    floatB = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 6; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("rep_lat", lat, 28);
    chk("rep_quot", floatQuot, 32'h40A00000);
    @(posedge clk);
    #1;
    chk("rep_busy_end", busy, 0);

    // start during the done cycle is ignored
    @(negedge clk);
    floatA = 32'h3F800000;
    floatB = 32'h3F800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("dc_done_seen", seen, 1);
    chk("dc_quot", floatQuot, 32'h3F800000);
    floatA = 32'h41A00000;
    floatB = 32'h40800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("dc_busy", busy, 0);
    seen = 0;
    for (int n = 0; n < 35; n++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("dc_no_done", seen, 0);
    chk("dc_quot_held", floatQuot, 32'h3F800000);

    // reset at edge 10 aborts the operation
    @(negedge clk);
    floatA = 32'h3F800000;
    floatB = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_quot", floatQuot, 0);
    chk("ar_done", done, 0);
    chk("ar_busy", busy, 0);
    chk("ar_dbz", divByZero, 0);
    chk("ar_inv", invalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("ar_no_done", seen, 0);
    run_op(32'h41A00000, 32'h40800000, "ar_after",
           q, dz, iv, lat);
    chk("ar_after_quot", q, 32'h40A00000);
    chk("ar_after_lat", lat, 28);
    chk("ar_after_dbz", dz, 0);
    chk("ar_after_inv", iv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
